// File: rtl/freq_select_scheduler_if.sv
// Stream and control bundle for freq_select_scheduler.
// master = scheduler side, slave = selector/consumer side.
interface freq_select_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 12
);
    logic                  enable;
    logic [CNT_WIDTH-1:0]  num_tones;
    logic                  rd_en_first;
    logic                  rd_en_second;
    logic [DATA_WIDTH-1:0] sel_dout;
    logic                  a_tvalid;
    logic                  a_tready;
    logic [DATA_WIDTH-1:0] a_tdata;
    logic                  a_tlast;
    logic                  b_tvalid;
    logic                  b_tready;
    logic [DATA_WIDTH-1:0] b_tdata;
    logic                  b_tlast;
    logic                  busy;
    logic [15:0]           frames_a;
    logic [15:0]           frames_b;

    modport master (
        input  enable, num_tones, sel_dout, a_tready, b_tready,
        output rd_en_first, rd_en_second,
        output a_tvalid, a_tdata, a_tlast,
        output b_tvalid, b_tdata, b_tlast,
        output busy, frames_a, frames_b
    );

    modport slave (
        output enable, num_tones, sel_dout, a_tready, b_tready,
        input  rd_en_first, rd_en_second,
        input  a_tvalid, a_tdata, a_tlast,
        input  b_tvalid, b_tdata, b_tlast,
        input  busy, frames_a, frames_b
    );
endinterface

// File: rtl/freq_select_scheduler.sv
// Round-robin read sequencer for the two selector strobes feeding two streams.
// Define FREQ_SCHED_STATS_EN to enable the frames_a/frames_b frame counters.
module freq_select_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int CNT_WIDTH  = 12
) (
    input logic                   dev_clk,
    input logic                   dev_rstn,
    freq_select_scheduler_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  nt_q, nt_d;
    logic [CNT_WIDTH-1:0]  idx_a_q, idx_a_d, idx_b_q, idx_b_d;
    logic [RD_LATENCY-1:0] tag_v_q, tag_v_d, tag_ch_q, tag_ch_d;
    logic                  rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic                  rr_q, rr_d;
    logic                  a_valid_q, a_valid_d, a_last_q, a_last_d;
    logic                  b_valid_q, b_valid_d, b_last_q, b_last_d;
    logic [DATA_WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;

    logic infl_a, infl_b, elig_a, elig_b, gnt_a, gnt_b;
    logic cap_a, cap_b, hs_a, hs_b, run;

    always_comb begin
        // tag channel bit: 0 = A, 1 = B
        infl_a = |(tag_v_q & ~tag_ch_q);
        infl_b = |(tag_v_q & tag_ch_q);
        run    = (state_q == S_RUN) && bus.enable;
        elig_a = run && !infl_a && !a_valid_q;
        elig_b = run && !infl_b && !b_valid_q;
        // rr_q names the channel preferred on a tie
        gnt_a  = elig_a && (!elig_b || !rr_q);
        gnt_b  = elig_b && (!elig_a || rr_q);
        cap_a  = tag_v_q[RD_LATENCY-1] && !tag_ch_q[RD_LATENCY-1];
        cap_b  = tag_v_q[RD_LATENCY-1] && tag_ch_q[RD_LATENCY-1];
        hs_a   = a_valid_q && bus.a_tready;
        hs_b   = b_valid_q && bus.b_tready;

        rd_a_d   = gnt_a;
        rd_b_d   = gnt_b;
        rr_d     = gnt_a ? 1'b1 : (gnt_b ? 1'b0 : rr_q);
        tag_v_d  = (tag_v_q << 1) | RD_LATENCY'(gnt_a | gnt_b);
        tag_ch_d = (tag_ch_q << 1) | RD_LATENCY'(gnt_b);

        state_d   = state_q;
        nt_d      = nt_q;
        idx_a_d   = idx_a_q;
        idx_b_d   = idx_b_q;
        a_valid_d = a_valid_q;
        a_last_d  = a_last_q;
        a_data_d  = a_data_q;
        b_valid_d = b_valid_q;
        b_last_d  = b_last_q;
        b_data_d  = b_data_q;

        if (cap_a) begin
            a_valid_d = 1'b1;
            a_data_d  = bus.sel_dout;
            a_last_d  = (idx_a_q == nt_q - CNT_WIDTH'(1));
            idx_a_d   = a_last_d ? '0 : idx_a_q + CNT_WIDTH'(1);
        end else if (hs_a) begin
            a_valid_d = 1'b0;
        end

        if (cap_b) begin
            b_valid_d = 1'b1;
            b_data_d  = bus.sel_dout;
            b_last_d  = (idx_b_q == nt_q - CNT_WIDTH'(1));
            idx_b_d   = b_last_d ? '0 : idx_b_q + CNT_WIDTH'(1);
        end else if (hs_b) begin
            b_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.enable && bus.num_tones != '0) begin
                    state_d = S_RUN;
                    nt_d    = bus.num_tones;
                    idx_a_d = '0;
                    idx_b_d = '0;
                end
            end
            S_RUN: begin
                if (!bus.enable) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (tag_v_q == '0 && !a_valid_q && !b_valid_q)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge dev_clk) begin
        if (!dev_rstn) begin
            state_q   <= S_IDLE;
            nt_q      <= '0;
            idx_a_q   <= '0;
            idx_b_q   <= '0;
            tag_v_q   <= '0;
            tag_ch_q  <= '0;
            rd_a_q    <= 1'b0;
            rd_b_q    <= 1'b0;
            rr_q      <= 1'b0;
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            a_data_q  <= '0;
            b_valid_q <= 1'b0;
            b_last_q  <= 1'b0;
            b_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            nt_q      <= nt_d;
            idx_a_q   <= idx_a_d;
            idx_b_q   <= idx_b_d;
            tag_v_q   <= tag_v_d;
            tag_ch_q  <= tag_ch_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            rr_q      <= rr_d;
            a_valid_q <= a_valid_d;
            a_last_q  <= a_last_d;
            a_data_q  <= a_data_d;
            b_valid_q <= b_valid_d;
            b_last_q  <= b_last_d;
            b_data_q  <= b_data_d;
        end
    end

`ifdef FREQ_SCHED_STATS_EN
    logic [15:0] frames_a_q, frames_a_d, frames_b_q, frames_b_d;

    always_comb begin
        frames_a_d = frames_a_q;
        frames_b_d = frames_b_q;
        if (hs_a && a_last_q && frames_a_q != 16'hFFFF)
            frames_a_d = frames_a_q + 16'd1;
        if (hs_b && b_last_q && frames_b_q != 16'hFFFF)
            frames_b_d = frames_b_q + 16'd1;
    end

    always_ff @(posedge dev_clk) begin
        if (!dev_rstn) begin
            frames_a_q <= '0;
            frames_b_q <= '0;
        end else begin
            frames_a_q <= frames_a_d;
            frames_b_q <= frames_b_d;
        end
    end

    assign bus.frames_a = frames_a_q;
    assign bus.frames_b = frames_b_q;
`else
    assign bus.frames_a = '0;
    assign bus.frames_b = '0;
`endif

    assign bus.rd_en_first  = rd_a_q;
    assign bus.rd_en_second = rd_b_q;
    assign bus.a_tvalid     = a_valid_q;
    assign bus.a_tdata      = a_data_q;
    assign bus.a_tlast      = a_last_q;
    assign bus.b_tvalid     = b_valid_q;
    assign bus.b_tdata      = b_data_q;
    assign bus.b_tlast      = b_last_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule
